// File: rtl/puf_challenge_sequencer.sv
// Arbiter-PUF challenge sequencer: LFSR challenges, launch pulses, response packing.
// Optional PUF_MAJORITY_VOTE_EN: three evaluations per challenge, majority-voted bit.
module puf_challenge_sequencer #(
    parameter int unsigned C_LENGTH    = 8,  // LFSR taps are fixed, so only 8 is valid
    parameter int unsigned RESP_BITS   = 8,
    parameter int unsigned SETTLE_CYC  = 2,
    parameter int unsigned CAPTURE_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [C_LENGTH-1:0]  seed,
    input  logic                 seed_load,
    output logic [C_LENGTH-1:0]  challenge,
    output logic                 launch,
    input  logic                 response_in,
    output logic [RESP_BITS-1:0] resp_data,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic                 busy
);

    localparam int unsigned CntW = $clog2(RESP_BITS + 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StLaunch,
        StSample,
        StDone
    } state_e;

    state_e                state_q;
    logic [C_LENGTH-1:0]   lfsr_q;
    logic                  launch_q;
    logic [RESP_BITS-1:0]  resp_data_q;
    logic                  resp_valid_q;
    logic                  busy_q;
    logic [CntW-1:0]       bit_cnt_q;
    logic [15:0]           cyc_cnt_q;
    logic [1:0]            sync_q;

    logic                  sync_resp;
    logic [C_LENGTH-1:0]   lfsr_next;
    logic [C_LENGTH-1:0]   seed_val;
    logic                  last_eval;
    logic                  vote_bit;

    assign sync_resp = sync_q[1];
    assign lfsr_next = {lfsr_q[C_LENGTH-2:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    // An all-zero seed would lock the LFSR up
    assign seed_val  = (seed == '0) ? C_LENGTH'(1) : seed;

`ifdef PUF_MAJORITY_VOTE_EN
    logic [1:0] eval_q;
    logic [1:0] ones_q;
    logic [1:0] ones_sum;

    assign ones_sum  = ones_q + {1'b0, sync_resp};
    assign last_eval = (eval_q == 2'd2);
    assign vote_bit  = (ones_sum >= 2'd2);
`else
    assign last_eval = 1'b1;
    assign vote_bit  = sync_resp;
`endif

    // Two-flop synchroniser for the asynchronous arbiter output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], response_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            lfsr_q       <= C_LENGTH'(1);
            launch_q     <= 1'b0;
            resp_data_q  <= '0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            bit_cnt_q    <= '0;
            cyc_cnt_q    <= '0;
`ifdef PUF_MAJORITY_VOTE_EN
            eval_q       <= 2'd0;
            ones_q       <= 2'd0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (seed_load) begin
                        lfsr_q <= seed_val;
                    end
                    if (start) begin
                        state_q     <= StSetup;
                        busy_q      <= 1'b1;
                        bit_cnt_q   <= '0;
                        cyc_cnt_q   <= '0;
                        resp_data_q <= '0;
`ifdef PUF_MAJORITY_VOTE_EN
                        eval_q      <= 2'd0;
                        ones_q      <= 2'd0;
`endif
                    end
                end
                StSetup: begin
                    if (cyc_cnt_q == 16'(SETTLE_CYC - 1)) begin
                        state_q   <= StLaunch;
                        launch_q  <= 1'b1;
                        cyc_cnt_q <= '0;
                    end else begin
                        cyc_cnt_q <= cyc_cnt_q + 16'd1;
                    end
                end
                StLaunch: begin
                    if (cyc_cnt_q == 16'(CAPTURE_CYC - 1)) begin
                        state_q   <= StSample;
                        launch_q  <= 1'b0;
                        cyc_cnt_q <= '0;
                    end else begin
                        cyc_cnt_q <= cyc_cnt_q + 16'd1;
                    end
                end
                StSample: begin
                    launch_q <= 1'b0;
                    if (last_eval) begin
                        resp_data_q <= {resp_data_q[RESP_BITS-2:0], vote_bit};
                        lfsr_q      <= lfsr_next;
                        bit_cnt_q   <= bit_cnt_q + CntW'(1);
`ifdef PUF_MAJORITY_VOTE_EN
                        eval_q      <= 2'd0;
                        ones_q      <= 2'd0;
`endif
                        if (bit_cnt_q == CntW'(RESP_BITS - 1)) begin
                            state_q      <= StDone;
                            resp_valid_q <= 1'b1;
                        end else begin
                            state_q <= StSetup;
                        end
                    end else begin
`ifdef PUF_MAJORITY_VOTE_EN
                        eval_q <= eval_q + 2'd1;
                        ones_q <= ones_sum;
`endif
                        state_q <= StSetup;
                    end
                end
                StDone: begin
                    if (resp_ready) begin
                        state_q      <= StIdle;
                        resp_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign challenge  = lfsr_q;
    assign launch     = launch_q;
    assign resp_data  = resp_data_q;
    assign resp_valid = resp_valid_q;
    assign busy       = busy_q;

endmodule
